// File: rtl/ldpc_enc_pkg.sv
// rtl/ldpc_enc_pkg.sv - shared state encoding and width helpers for the parallel LDPC encoder
package ldpc_enc_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CALC = 3'd2,
    ASM  = 3'd3,
    SWAP = 3'd4,
    DONE = 3'd5
  } state_t;

  function automatic int info_len(input int code_len, input int chk_len);
    return code_len - chk_len;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ldpc_swap_table.sv
// rtl/ldpc_swap_table.sv - column-swap register file with count, write gating and drop error pulse
module ldpc_swap_table
  import ldpc_enc_pkg::*;
#(
  parameter int SWAP_MAX = 8,
  parameter int IDX_W    = 8,
  parameter int SW_W     = 4,
  parameter int AW       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             swap_we,
  input  logic [AW-1:0]    swap_addr,
  input  logic [IDX_W-1:0] swap_a,
  input  logic [IDX_W-1:0] swap_b,
  input  logic             swap_cnt_we,
  input  logic [SW_W-1:0]  swap_cnt,
  input  logic [AW-1:0]    rd_idx,
  output logic [IDX_W-1:0] rd_a,
  output logic [IDX_W-1:0] rd_b,
  output logic [SW_W-1:0]  count,
  output logic             swap_err
);

  logic [IDX_W-1:0] tab_a [SWAP_MAX];
  logic [IDX_W-1:0] tab_b [SWAP_MAX];
  logic             addr_ok;
  logic             cnt_big;

  assign addr_ok = int'(swap_addr) < SWAP_MAX;
  assign cnt_big = int'(swap_cnt) > SWAP_MAX;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SWAP_MAX; i++) begin
        tab_a[i] <= '0;
        tab_b[i] <= '0;
      end
      count    <= '0;
      swap_err <= 1'b0;
    end else begin
      // An oversized count is still loaded (clamped) but flagged.
      swap_err <= (swap_we && !(wr_en && addr_ok)) ||
                  (swap_cnt_we && (!wr_en || cnt_big));
      if (swap_we && wr_en && addr_ok) begin
        tab_a[swap_addr] <= swap_a;
        tab_b[swap_addr] <= swap_b;
      end
      if (swap_cnt_we && wr_en) begin
        count <= cnt_big ? SW_W'(SWAP_MAX) : swap_cnt;
      end
    end
  end

  assign rd_a = tab_a[rd_idx];
  assign rd_b = tab_b[rd_idx];

endmodule

// File: rtl/ldpc_encoder_par.sv
// rtl/ldpc_encoder_par.sv - systematic LDPC encoder, PAR parity rows per ROM word, column-swap output stage
module ldpc_encoder_par
  import ldpc_enc_pkg::*;
#(
  parameter int  CODE_LEN = 256,
  parameter int  CHK_LEN  = 128,
  parameter int  PAR      = 4,
  parameter int  SWAP_MAX = 8,
  parameter int  IDX_W    = $clog2(CODE_LEN),
  parameter int  SW_W     = $clog2(SWAP_MAX + 1),
  localparam int INFO_LEN = info_len(CODE_LEN, CHK_LEN),
  localparam int AW       = idx_w(SWAP_MAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    info_valid,
  input  logic [INFO_LEN-1:0]     info_word,
  output logic                    info_ready,
  output logic                    pi_req,
  input  logic                    pi_ack,
  input  logic                    pi_valid,
  input  logic [PAR*INFO_LEN-1:0] pi_rows,
  input  logic                    swap_we,
  input  logic [AW-1:0]           swap_addr,
  input  logic [IDX_W-1:0]        swap_a,
  input  logic [IDX_W-1:0]        swap_b,
  input  logic                    swap_cnt_we,
  input  logic [SW_W-1:0]         swap_cnt,
  output logic                    swap_err,
  output logic                    code_valid,
  output logic [CODE_LEN-1:0]     code_out,
  input  logic                    code_ack,
  output logic                    busy
);

  localparam int            ROWS     = CHK_LEN / PAR;
  localparam int            RW       = idx_w(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  if (CHK_LEN % PAR != 0) begin : g_par_check
    $error("ldpc_encoder_par: CHK_LEN must be a multiple of PAR");
  end

  state_t                  state;
  logic [INFO_LEN-1:0]     info;
  logic [CHK_LEN-1:0]      parity;
  logic [RW-1:0]           row;
  logic [AW-1:0]           sw_idx;
  logic [PAR-1:0]          lane_bits;
  logic [CHK_LEN+PAR-1:0]  par_shift;
  logic [CODE_LEN-1:0]     swapped;
  logic [IDX_W-1:0]        rd_a;
  logic [IDX_W-1:0]        rd_b;
  logic [SW_W-1:0]         swap_count;

  for (genvar l = 0; l < PAR; l++) begin : g_lane
    assign lane_bits[l] = ^(pi_rows[l*INFO_LEN +: INFO_LEN] & info);
  end

  // New lanes enter at the top; after ROWS words row r lane l sits at bit r*PAR+l.
  assign par_shift = {lane_bits, parity};

  always_comb begin
    swapped       = code_out;
    swapped[rd_a] = code_out[rd_b];
    swapped[rd_b] = code_out[rd_a];
  end

  ldpc_swap_table #(
    .SWAP_MAX (SWAP_MAX),
    .IDX_W    (IDX_W),
    .SW_W     (SW_W),
    .AW       (AW)
  ) u_swap_table (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (state == IDLE),
    .swap_we     (swap_we),
    .swap_addr   (swap_addr),
    .swap_a      (swap_a),
    .swap_b      (swap_b),
    .swap_cnt_we (swap_cnt_we),
    .swap_cnt    (swap_cnt),
    .rd_idx      (sw_idx),
    .rd_a        (rd_a),
    .rd_b        (rd_b),
    .count       (swap_count),
    .swap_err    (swap_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      info       <= '0;
      parity     <= '0;
      row        <= '0;
      sw_idx     <= '0;
      info_ready <= 1'b1;
      pi_req     <= 1'b0;
      code_valid <= 1'b0;
      code_out   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (info_valid) begin
            info       <= info_word;
            row        <= '0;
            pi_req     <= 1'b1;
            info_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (pi_ack) begin
            pi_req <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (pi_valid) begin
            parity <= par_shift[CHK_LEN+PAR-1:PAR];
            row    <= row + 1'b1;
            if (row == LAST_ROW) state <= ASM;
          end
        end
        ASM: begin
          code_out <= {parity, info};
          if (swap_count == '0) begin
            code_valid <= 1'b1;
            state      <= DONE;
          end else begin
            sw_idx <= AW'(swap_count - 1'b1);
            state  <= SWAP;
          end
        end
        SWAP: begin
          code_out <= swapped;
          // Descending walk ends on an unsigned equality, never a signed >= 0.
          if (sw_idx == '0) begin
            code_valid <= 1'b1;
            state      <= DONE;
          end else begin
            sw_idx <= sw_idx - 1'b1;
          end
        end
        DONE: begin
          if (code_ack) begin
            code_valid <= 1'b0;
            info_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_encoder_par.sv
// tb/tb_ldpc_encoder_par.sv - randomized model-checked bench for ldpc_encoder_par
module tb_ldpc_encoder_par;

  localparam int CODE_LEN = 16;
  localparam int CHK_LEN  = 8;
  localparam int PAR      = 2;
  localparam int SWAP_MAX = 8;
  localparam int ROWS     = CHK_LEN / PAR;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        info_valid = 1'b0;
  logic [7:0]  info_word = '0;
  logic        info_ready;
  logic        pi_req;
  logic        pi_ack = 1'b0;
  logic        pi_valid = 1'b0;
  logic [15:0] pi_rows = '0;
  logic        swap_we = 1'b0;
  logic [2:0]  swap_addr = '0;
  logic [3:0]  swap_a = '0;
  logic [3:0]  swap_b = '0;
  logic        swap_cnt_we = 1'b0;
  logic [3:0]  swap_cnt = '0;
  logic        swap_err;
  logic        code_valid;
  logic [15:0] code_out;
  logic        code_ack = 1'b0;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [7:0]  pi_mat [8];
  logic [3:0]  tb_a [8];
  logic [3:0]  tb_b [8];
  int          tb_cnt = 0;
  int          ack_dly = 0;
  int          gap_mode = 0;
  logic [15:0] exp_code = '0;

  ldpc_encoder_par #(
    .CODE_LEN (CODE_LEN),
    .CHK_LEN  (CHK_LEN),
    .PAR      (PAR),
    .SWAP_MAX (SWAP_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .info_valid  (info_valid),
    .info_word   (info_word),
    .info_ready  (info_ready),
    .pi_req      (pi_req),
    .pi_ack      (pi_ack),
    .pi_valid    (pi_valid),
    .pi_rows     (pi_rows),
    .swap_we     (swap_we),
    .swap_addr   (swap_addr),
    .swap_a      (swap_a),
    .swap_b      (swap_b),
    .swap_cnt_we (swap_cnt_we),
    .swap_cnt    (swap_cnt),
    .swap_err    (swap_err),
    .code_valid  (code_valid),
    .code_out    (code_out),
    .code_ack    (code_ack),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: parity bit k is the parity of the ones in (PI row k & info);
  // swaps are then applied from the highest active entry down to entry 0.
  function automatic logic [15:0] model_code(input logic [7:0] info);
    logic [7:0]  par;
    logic [15:0] c;
    logic        t;
    for (int k = 0; k < 8; k++) par[k] = ($countones(pi_mat[k] & info) % 2) == 1;
    c = {par, info};
    for (int j = tb_cnt - 1; j >= 0; j--) begin
      t = c[tb_a[j]];
      c[tb_a[j]] = c[tb_b[j]];
      c[tb_b[j]] = t;
    end
    return c;
  endfunction

  task automatic set_identity();
    for (int k = 0; k < 8; k++) pi_mat[k] = 8'(1 << k);
  endtask

  // PI ROM: optional ack delay (with junk pi_valid meant to be ignored) and optional gap cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (pi_req && rst) begin
        for (int d = 0; d < ack_dly; d++) begin
          pi_valid = 1'b1;
          pi_rows  = 16'($urandom);
          @(posedge clk); #1;
        end
        pi_valid = 1'b0;
        pi_ack   = 1'b1;
        @(posedge clk); #1;
        pi_ack = 1'b0;
        for (int w = 0; w < ROWS; w++) begin
          if (gap_mode != 0) begin
            pi_valid = 1'b0;
            pi_rows  = 16'($urandom);
            @(posedge clk); #1;
          end
          pi_valid = 1'b1;
          pi_rows  = {pi_mat[2*w+1], pi_mat[2*w]};
          @(posedge clk); #1;
        end
        pi_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("ready_vs_busy", info_ready, !busy);
      if (code_valid) check("code_out", code_out, exp_code);
    end
  end

  task automatic chk_reset_outs(input string tag);
    check({tag, "_info_ready"}, info_ready, 1);
    check({tag, "_pi_req"}, pi_req, 0);
    check({tag, "_swap_err"}, swap_err, 0);
    check({tag, "_code_valid"}, code_valid, 0);
    check({tag, "_code_out"}, code_out, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wr_entry(input logic [2:0] addr, input logic [3:0] a, input logic [3:0] b);
    @(posedge clk); #1;
    swap_we = 1'b1; swap_addr = addr; swap_a = a; swap_b = b;
    @(posedge clk); #1;
    swap_we = 1'b0;
    tb_a[addr] = a;
    tb_b[addr] = b;
    check("wr_entry_err", swap_err, 0);
  endtask

  task automatic wr_cnt(input int c);
    @(posedge clk); #1;
    swap_cnt_we = 1'b1; swap_cnt = 4'(c);
    @(posedge clk); #1;
    swap_cnt_we = 1'b0;
    tb_cnt = (c > SWAP_MAX) ? SWAP_MAX : c;
    check("cnt_err", swap_err, (c > SWAP_MAX) ? 1 : 0);
    @(posedge clk); #1;
    check("cnt_err_end", swap_err, 0);
  endtask

  task automatic encode(input logic [7:0] info, input int hold, input bit we_too,
                        input logic [2:0] wa, input logic [3:0] a, input logic [3:0] b);
    int n;
    int acc;
    int exp_lat;
    bit rdy_bad;
    n = 0;
    while (!info_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("ready_before", info_ready, 1);
    if (we_too) begin
      tb_a[wa] = a; tb_b[wa] = b;
      swap_we = 1'b1; swap_addr = wa; swap_a = a; swap_b = b;
    end
    exp_code   = model_code(info);
    info_valid = 1'b1;
    info_word  = info;
    @(posedge clk); #1;
    acc = cyc;
    info_valid = 1'b0;
    if (we_too) begin
      swap_we = 1'b0;
      check("we_at_accept_err", swap_err, 0);
    end
    exp_lat = 7 + tb_cnt + ack_dly + ((gap_mode != 0) ? ROWS : 0);
    rdy_bad = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (info_ready) rdy_bad = 1'b1;
    end while (!code_valid && n < 300);
    check("valid_seen", code_valid, 1);
    check("latency", cyc - acc + 1, exp_lat);
    check("ready_low", rdy_bad, 0);
    for (int h = 0; h < hold; h++) begin
      info_valid = 1'b1;
      info_word  = ~info;
      @(negedge clk);
      check("hold_valid", code_valid, 1);
      check("hold_stable", code_out, exp_code);
      check("hold_no_accept", info_ready, 0);
    end
    info_valid = 1'b0;
    code_ack   = 1'b1;
    @(posedge clk); #1;
    code_ack = 1'b0;
    @(negedge clk);
    check("after_ack_valid", code_valid, 0);
    check("after_ack_ready", info_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin tb_a[i] = '0; tb_b[i] = '0; end
    set_identity();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed identity-PI cases with hand-computed codewords.
    check("model_a5a5", model_code(8'hA5), 16'hA5A5);
    encode(8'hA5, 0, 1'b0, 3'd0, 4'd0, 4'd0);
    wr_entry(3'd0, 4'd1, 4'd8);
    wr_cnt(1);
    check("model_a4a7", model_code(8'hA5), 16'hA4A7);
    encode(8'hA5, 1, 1'b0, 3'd0, 4'd0, 4'd0);
    wr_entry(3'd1, 4'd8, 4'd9);
    wr_cnt(2);
    check("model_a6a5", model_code(8'hA5), 16'hA6A5);
    encode(8'hA5, 0, 1'b0, 3'd0, 4'd0, 4'd0);

    // Stalls: ack after 3 cycles, pi_valid every other cycle.
    ack_dly = 3; gap_mode = 1;
    encode(8'hA5, 2, 1'b0, 3'd0, 4'd0, 4'd0);

    // Table write during CALC is dropped.
    ack_dly = 0;
    wr_cnt(1);
    fork
      encode(8'hA5, 0, 1'b0, 3'd0, 4'd0, 4'd0);
      begin : calc_write
        int n;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!pi_valid && n < 60);
        check("calc_seen", pi_valid, 1);
        swap_we = 1'b1; swap_addr = 3'd0; swap_a = 4'd3; swap_b = 4'd4;
        @(posedge clk); #1;
        swap_we = 1'b0;
        check("calc_we_err", swap_err, 1);
        @(posedge clk); #1;
        check("calc_we_err_end", swap_err, 0);
      end
    join
    gap_mode = 0;
    encode(8'hA5, 0, 1'b0, 3'd0, 4'd0, 4'd0);

    // Oversized count clamps to SWAP_MAX.
    for (int k = 0; k < 8; k++) wr_entry(3'(k), 4'($urandom), 4'($urandom));
    wr_cnt(15);
    for (int k = 0; k < 8; k++) pi_mat[k] = 8'($urandom);
    encode(8'($urandom), 0, 1'b0, 3'd0, 4'd0, 4'd0);

    // Reset in the middle of the swap walk.
    @(posedge clk); #1;
    info_valid = 1'b1; info_word = 8'h3C;
    @(posedge clk); #1;
    info_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("in_swap_busy", busy, 1);
    rst = 1'b0;
    tb_cnt = 0;
    for (int i = 0; i < 8; i++) begin tb_a[i] = '0; tb_b[i] = '0; end
    @(negedge clk);
    chk_reset_outs("midreset");
    @(posedge clk); #1;
    rst = 1'b1;
    set_identity();
    check("model_clean", model_code(8'hA5), 16'hA5A5);
    encode(8'hA5, 10, 1'b0, 3'd0, 4'd0, 4'd0);

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      int c;
      for (int k = 0; k < 8; k++) pi_mat[k] = 8'($urandom);
      c = $urandom_range(0, 9);
      for (int k = 0; k < ((c > 8) ? 8 : c); k++) begin
        logic [3:0] a;
        a = 4'($urandom);
        wr_entry(3'(k), a, ($urandom_range(0, 3) == 0) ? a : 4'($urandom));
      end
      wr_cnt(c);
      ack_dly  = $urandom_range(0, 3);
      gap_mode = $urandom_range(0, 1);
      encode(8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             3'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldpc_encoder_par.md
Name: ldpc_encoder_par

Overview:
- Parametrised systematic LDPC encoder, successor to the single-row encoder.
- Accepts an INFO_LEN-bit information word and streams the PI (parity-generator) matrix from ROM, PAR rows per word, computing PAR parity bits per cycle.
- Assembles {parity, info} and applies a runtime-loadable column-swap table (up to SWAP_MAX swaps).
- Sits between the random-sequence source and the channel/decoder control, with valid/ack handshakes on every side.

Parameters:
- CODE_LEN, 256, codeword length in bits.
- CHK_LEN, 128, parity bits (rows of H); INFO_LEN = CODE_LEN - CHK_LEN is a derived localparam.
- PAR, 4, PI rows delivered per ROM word; CHK_LEN % PAR == 0 is required (elaboration error otherwise).
- SWAP_MAX, 8, swap-table depth.
- IDX_W, $clog2(CODE_LEN), width of a bit index.
- SW_W, $clog2(SWAP_MAX+1), width of the swap count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- info_valid  in  1  info word offered.
- info_word  in  INFO_LEN  information bits.
- info_ready  out  1  encoder can accept (high only in IDLE).
- pi_req  out  1  read request to PI ROM.
- pi_ack  in  1  ROM accepted request.
- pi_valid  in  1  pi_rows valid this cycle.
- pi_rows  in  PAR*INFO_LEN  lane l = bits [(l+1)*INFO_LEN-1 : l*INFO_LEN] = PI row r*PAR+l.
- swap_we  in  1  swap-table write strobe.
- swap_addr  in  $clog2(SWAP_MAX)  entry index.
- swap_a, swap_b  in  IDX_W each  bit positions to exchange.
- swap_cnt_we  in  1  load swap count.
- swap_cnt  in  SW_W  active entries (0..SWAP_MAX).
- swap_err  out  1  one-cycle pulse when a table/count write is dropped.
- code_valid  out  1  codeword available.
- code_out  out  CODE_LEN  encoded codeword.
- code_ack  in  1  consumer took the codeword.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: info_ready=1, pi_req=0, swap_err=0, code_valid=0, code_out=0, busy=0, swap count=0, table entries=0, state=IDLE, row counter=0.
- Reset asserted mid-operation aborts immediately to these values; the swap table is also cleared.
- IDLE
  - On info_valid & info_ready: capture info_word, assert pi_req, clear the row counter, go to REQ.
- REQ
  - pi_req is held until pi_ack; on pi_ack drop pi_req and go to CALC.
- CALC
  - On each pi_valid: parity[r*PAR+l] = XOR-reduce(lane_l & info) for l = 0..PAR-1, then r++.
  - No progress without pi_valid; pi_valid in any other state is ignored.
  - After CHK_LEN/PAR accepted words go to ASM.
- ASM (1 cycle)
  - code_out <= {parity, info}; parity occupies the MSBs.
  - Load swap index j = count-1; if count == 0 go to DONE, else go to SWAP.
- SWAP
  - One entry per cycle, order j = count-1 down to 0.
  - Exchange code_out[a_j] and code_out[b_j] using pre-swap values of that cycle; a == b is a no-op.
  - After j == 0 go to DONE.
  - Explicit unsigned terminate test; no signed >= 0 comparison.
- DONE
  - code_valid=1, code_out held stable until code_ack.
  - Cycle after code_ack: code_valid=0, state IDLE.
  - info_ready rises in that same cycle; a new word is accepted at the earliest one cycle after.
- Swap-table writes
  - Accepted only in IDLE; otherwise the write is dropped and swap_err pulses for one cycle.
  - swap_cnt > SWAP_MAX is clamped to SWAP_MAX and also pulses swap_err.
  - Simultaneous swap_we and info accept in IDLE: the write takes effect and applies to that codeword.
- Latency with no stalls and immediate pi_ack: 1 (accept) + 1 (REQ) + CHK_LEN/PAR + 1 (ASM) + count, from info accept to code_valid.

Decomposition:
- Package ldpc_enc_pkg holds:
  - state enum IDLE/REQ/CALC/ASM/SWAP/DONE;
  - INFO_LEN derivation and the width helper functions.
- Sub-module ldpc_swap_table: SWAP_MAX-entry register file plus count register, write-gating and error pulse, one combinational read port.
- Parity lanes stay inline as a generate loop.

Test Plan:
All scenarios use CODE_LEN=16, CHK_LEN=8, PAR=2.
- Identity PI (row k one-hot bit k), info=8'hA5, swap count 0 -> parity=8'hA5, code_out=16'hA5A5, code_valid 1+1+4+1=7 cycles after accept.
- Same stimulus, entry0=(1,8), count=1 -> code_out=16'hA4A7.
- Entry0=(1,8), entry1=(8,9), count=2 -> 16'hA6A5 (descending order verified; ascending order would give 16'hA4A7).
- pi_valid toggling every other cycle and pi_ack delayed 3 cycles -> identical code_out, latency increased by the stall count; info_ready stays 0 throughout.
- swap_we asserted during CALC -> swap_err one-cycle pulse, table unchanged; swap_cnt=15 written in IDLE -> count reads 8, swap_err pulses.
- rst low during SWAP -> all outputs at reset values next edge; next encode with count 0 yields clean 16'hA5A5; code_ack withheld 10 cycles -> code_out stable, no second accept.
